scene_raygen_cfg: RTL and testbench

//  Runtime-loadable scene configuration with a per-pixel ray-target generator. Holds camera,

---
 rtl/scene_raygen_cfg.sv | 252 +++++++++++++++++++++++++
 tb/tb_scene_raygen_cfg.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_raygen_cfg.sv
// scene_raygen_cfg
// Double-buffered scene configuration (camera, pixel-plane origin, pixel-step
// vectors, lanterns) with a per-pixel location generator streamed over
// valid/ready. Writes go to a shadow bank; the active bank is refreshed only
// when a frame starts, so a frame always renders with one consistent setup.
module scene_raygen_cfg #(
  parameter  int COORD_W  = 12,
  parameter  int N_LIGHTS = 2,
  parameter  int H_RES    = 320,
  parameter  int V_RES    = 240,
  parameter  int ADDR_W   = $clog2(4 + N_LIGHTS),
  localparam int COL_W    = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int ROW_W    = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_wr_valid,
  input  logic [ADDR_W-1:0]                      cfg_wr_addr,
  input  logic [3*COORD_W-1:0]                   cfg_wr_data,
  output logic                                   cfg_wr_err,
  input  logic                                   frame_start,
  output logic                                   frame_busy,
  output logic                                   frame_done,
  output logic [2:0][COORD_W-1:0]                camera_location,
  output logic [N_LIGHTS-1:0][2:0][COORD_W-1:0]  lantern_location,
  output logic                                   pix_valid,
  input  logic                                   pix_ready,
  output logic [2:0][COORD_W-1:0]                pix_loc,
  output logic [COL_W-1:0]                       pix_col,
  output logic [ROW_W-1:0]                       pix_row,
  output logic                                   pix_last
);

  // Register map: 0 camera, 1 begin, 2 delta_u, 3 delta_v, 4+k lantern k.
  localparam int NUM_REGS  = 4 + N_LIGHTS;
  localparam int IDX_CAM   = 0;
  localparam int IDX_BEGIN = 1;
  localparam int IDX_DU    = 2;
  localparam int IDX_DV    = 3;
  localparam int IDX_LANT  = 4;

  // One 3-D vector, x in the least significant component.
  typedef logic [2:0][COORD_W-1:0] vec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Power-up / reset contents of each configuration entry.
  function automatic vec_t default_vec(input int idx);
    vec_t v;
    v = '0;
    if (idx == IDX_CAM) begin
      v[0] = COORD_W'(4090);
      v[1] = COORD_W'(2000);
      v[2] = COORD_W'(1002);
    end else if (idx == IDX_BEGIN) begin
      v[0] = COORD_W'(2785);
      v[1] = COORD_W'(1541);
      v[2] = COORD_W'(798);
    end else if (idx == IDX_DU) begin
      v[0] = COORD_W'(36);
      v[1] = COORD_W'(89);
      v[2] = COORD_W'(82);
    end else if (idx == IDX_LANT) begin
      v[0] = COORD_W'(3242);
      v[1] = COORD_W'(1731);
      v[2] = COORD_W'(761);
    end
    return v;
  endfunction

  // Component-wise add; each lane wraps modulo 2^COORD_W, so a
  // two's-complement delta steps backwards without any special casing.
  function automatic vec_t vadd(input vec_t a, input vec_t b);
    vec_t s;
    for (int k = 0; k < 3; k++) begin
      s[k] = a[k] + b[k];
    end
    return s;
  endfunction

  vec_t r_shadow [NUM_REGS];
  vec_t r_active [NUM_REGS];
  vec_t w_commit_val [NUM_REGS];

  logic [NUM_REGS-1:0] w_hit;
  logic                w_addr_bad;
  logic                w_commit;

  state_t r_state;
  state_t w_state_next;

  vec_t             r_loc;
  vec_t             r_row_acc;
  vec_t             w_row_next;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_done;
  logic             r_wr_err;

  logic w_accept;
  logic w_col_end;
  logic w_row_end;
  logic w_at_last;

  // ------------------------------------------------------------------
  // Configuration banks
  // ------------------------------------------------------------------

  assign w_addr_bad = cfg_wr_valid && (32'(cfg_wr_addr) >= 32'(NUM_REGS));
  assign w_commit   = (r_state == ST_IDLE) && frame_start;

  // Per-entry write decode and commit value. A write landing in the same
  // cycle as the commit is forwarded so it takes effect for this frame.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    assign w_hit[gi]        = cfg_wr_valid && (32'(cfg_wr_addr) == 32'(gi));
    assign w_commit_val[gi] = w_hit[gi] ? vec_t'(cfg_wr_data) : r_shadow[gi];
  end

  // Shadow bank: absorbs every in-range write, whatever the frame state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= default_vec(i);
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_hit[i]) begin
          r_shadow[i] <= vec_t'(cfg_wr_data);
        end
      end
    end
  end

  // Active bank: refreshed from the shadow (plus bypassed write) on commit only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= default_vec(i);
      end
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= w_commit_val[i];
      end
    end
  end

  // Out-of-range write indication, one cycle after the offending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_addr_bad;
    end
  end

  assign cfg_wr_err      = r_wr_err;
  assign camera_location = r_active[IDX_CAM];

  for (genvar gi = 0; gi < N_LIGHTS; gi++) begin : g_lantern
    assign lantern_location[gi] = r_active[IDX_LANT + gi];
  end

  // ------------------------------------------------------------------
  // Frame sequencing
  // ------------------------------------------------------------------

  assign w_accept   = pix_valid && pix_ready;
  assign w_col_end  = (r_col == COL_W'(H_RES - 1));
  assign w_row_end  = (r_row == ROW_W'(V_RES - 1));
  assign w_at_last  = w_col_end && w_row_end;
  assign w_row_next = vadd(r_row_acc, r_active[IDX_DV]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start from IDLE, leave RUN only when the last pixel goes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (frame_start) w_state_next = ST_RUN;
      ST_RUN:  if (w_accept && w_at_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: a pixel is on offer for the whole of RUN.
  always_comb begin
    pix_valid  = 1'b0;
    frame_busy = 1'b0;
    pix_last   = 1'b0;
    if (r_state == ST_RUN) begin
      pix_valid  = 1'b1;
      frame_busy = 1'b1;
      pix_last   = w_at_last;
    end
  end

  // End-of-frame pulse, raised the cycle after the final pixel is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_RUN) && w_accept && w_at_last;
    end
  end

  assign frame_done = r_done;

  // ------------------------------------------------------------------
  // Pixel location generator
  // ------------------------------------------------------------------

  // Walk the pixel plane: step by delta_u along a row; at row end restart
  // from the row accumulator advanced by delta_v. Holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loc     <= '0;
      r_row_acc <= '0;
      r_col     <= '0;
      r_row     <= '0;
    end else if (w_commit) begin
      r_loc     <= w_commit_val[IDX_BEGIN];
      r_row_acc <= w_commit_val[IDX_BEGIN];
      r_col     <= '0;
      r_row     <= '0;
    end else if (w_accept && !w_at_last) begin
      if (w_col_end) begin
        r_col     <= '0;
        r_row     <= r_row + ROW_W'(1);
        r_row_acc <= w_row_next;
        r_loc     <= w_row_next;
      end else begin
        r_col     <= r_col + COL_W'(1);
        r_loc     <= vadd(r_loc, r_active[IDX_DU]);
      end
    end
  end

  assign pix_loc = r_loc;
  assign pix_col = r_col;
  assign pix_row = r_row;

endmodule

// File: tb/tb_scene_raygen_cfg.sv
// Testbench for scene_raygen_cfg: random/directed stimulus, reference model of
// the configuration banks and the pixel plane, queue-based scoreboard.
module tb_scene_raygen_cfg;

  localparam int CW   = 12;
  localparam int NL   = 2;
  localparam int H    = 3;
  localparam int V    = 2;
  localparam int NREG = 4 + NL;
  localparam int AW   = $clog2(NREG);
  localparam int CLW  = $clog2(H);
  localparam int RWW  = (V > 1) ? $clog2(V) : 1;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         cfg_wr_valid = 1'b0;
  logic [AW-1:0]                cfg_wr_addr = '0;
  logic [3*CW-1:0]              cfg_wr_data = '0;
  logic                         cfg_wr_err;
  logic                         frame_start = 1'b0;
  logic                         frame_busy;
  logic                         frame_done;
  logic [2:0][CW-1:0]           camera_location;
  logic [NL-1:0][2:0][CW-1:0]   lantern_location;
  logic                         pix_valid;
  logic                         pix_ready = 1'b0;
  logic [2:0][CW-1:0]           pix_loc;
  logic [CLW-1:0]               pix_col;
  logic [RWW-1:0]               pix_row;
  logic                         pix_last;

  always #5 clk = ~clk;

  scene_raygen_cfg #(
    .COORD_W (CW),
    .N_LIGHTS(NL),
    .H_RES   (H),
    .V_RES   (V)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_valid    (cfg_wr_valid),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_data     (cfg_wr_data),
    .cfg_wr_err      (cfg_wr_err),
    .frame_start     (frame_start),
    .frame_busy      (frame_busy),
    .frame_done      (frame_done),
    .camera_location (camera_location),
    .lantern_location(lantern_location),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_loc         (pix_loc),
    .pix_col         (pix_col),
    .pix_row         (pix_row),
    .pix_last        (pix_last)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [3*CW-1:0] loc;
    int              col;
    int              row;
    bit              last;
  } pix_t;

  pix_t exp_q[$];
  int   sh  [NREG][3];
  int   act [NREG][3];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 never

  function automatic logic [3*CW-1:0] pk(input int x, input int y, input int z);
    return {CW'(z), CW'(y), CW'(x)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic model_defaults();
    int d [NREG][3];
    for (int i = 0; i < NREG; i++) for (int k = 0; k < 3; k++) d[i][k] = 0;
    d[0][0] = 4090; d[0][1] = 2000; d[0][2] = 1002;
    d[1][0] = 2785; d[1][1] = 1541; d[1][2] = 798;
    d[2][0] = 36;   d[2][1] = 89;   d[2][2] = 82;
    d[4][0] = 3242; d[4][1] = 1731; d[4][2] = 761;
    sh  = d;
    act = d;
  endtask

  // Every pixel of a frame: begin + col*delta_u + row*delta_v, each lane mod 2^CW.
  task automatic push_frame();
    pix_t p;
    int   c3 [3];
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        for (int k = 0; k < 3; k++)
          c3[k] = (act[1][k] + c * act[2][k] + r * act[3][k]) % (1 << CW);
        p.loc  = pk(c3[0], c3[1], c3[2]);
        p.col  = c;
        p.row  = r;
        p.last = (c == H - 1) && (r == V - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_active(input string tag);
    chk({tag, "_camera"},   camera_location,     pk(act[0][0], act[0][1], act[0][2]));
    chk({tag, "_lantern0"}, lantern_location[0], pk(act[4][0], act[4][1], act[4][2]));
    chk({tag, "_lantern1"}, lantern_location[1], pk(act[5][0], act[5][1], act[5][2]));
  endtask

  // One config write; error flag checked the cycle after, and its fall for bad writes.
  task automatic cfg_write(input int a, input int x, input int y, input int z);
    bit bad;
    bad = (a >= NREG);
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = a[AW-1:0];
    cfg_wr_data  = pk(x, y, z);
    if (!bad) begin
      sh[a][0] = x % (1 << CW); sh[a][1] = y % (1 << CW); sh[a][2] = z % (1 << CW);
    end
    step();
    cfg_wr_valid = 1'b0;
    chk("cfg_wr_err", cfg_wr_err, bad);
    if (bad) begin
      step();
      chk("cfg_wr_err_pulse_end", cfg_wr_err, 1'b0);
    end
  endtask

  // frame_start, optionally with a same-cycle write; commits only when idle.
  task automatic start_frame(input bit with_wr, input int a, input int x, input int y, input int z);
    bit idle;
    idle = (exp_q.size() == 0);
    frame_start = 1'b1;
    if (with_wr) begin
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = a[AW-1:0];
      cfg_wr_data  = pk(x, y, z);
      if (a < NREG) begin
        sh[a][0] = x % (1 << CW); sh[a][1] = y % (1 << CW); sh[a][2] = z % (1 << CW);
      end
    end
    if (idle) begin
      act = sh;
      push_frame();
    end
    step();
    frame_start  = 1'b0;
    cfg_wr_valid = 1'b0;
    if (idle) chk("frame_busy_after_start", frame_busy, 1'b1);
    check_active("start");
  endtask

  task automatic wait_frame_end();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      step();
      t++;
    end
    if (t >= 400) begin
      fail_now("frame_timeout");
      exp_q.delete();
    end
    step();
    step();
    chk("frame_busy_after_end", frame_busy, 1'b0);
    chk("pix_valid_after_end", pix_valid, 1'b0);
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ~pix_ready;
      2: pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  bit                        mon_stall = 0;
  bit                        mon_done_pend = 0;
  logic [3*CW+CLW+RWW:0]     mon_held;

  always @(negedge clk) begin
    pix_t p;
    if (rst) begin
      mon_stall     = 0;
      mon_done_pend = 0;
    end else begin
      chk("frame_done", frame_done, mon_done_pend);
      mon_done_pend = 0;
      if (mon_stall) begin
        if (!pix_valid) fail_now("stall_valid_dropped");
        else chk("stall_hold", {pix_loc, pix_col, pix_row, pix_last}, mon_held);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pixel");
        end else begin
          p = exp_q.pop_front();
          chk("pix_loc",  pix_loc,  p.loc);
          chk("pix_col",  pix_col,  p.col[CLW-1:0]);
          chk("pix_row",  pix_row,  p.row[RWW-1:0]);
          chk("pix_last", pix_last, p.last);
          $display("pixel r%0d c%0d loc=%0h last=%0b", p.row, p.col, pix_loc, pix_last);
          if (p.last) mon_done_pend = 1;
        end
      end
      mon_stall = pix_valid && !pix_ready;
      mon_held  = {pix_loc, pix_col, pix_row, pix_last};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    model_defaults();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // 1: reset state
    check_active("reset");
    chk("reset_pix_valid",  pix_valid,  1'b0);
    chk("reset_frame_busy", frame_busy, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_cfg_wr_err", cfg_wr_err, 1'b0);
    chk("reset_pix_last",   pix_last,   1'b0);
    chk("reset_pix_loc",    pix_loc,    '0);
    chk("reset_pix_colrow", {pix_col, pix_row}, '0);

    // 2: gap-free frame with delta_v=(0,0,10)
    ready_mode = 0;
    cfg_write(3, 0, 0, 10);
    start_frame(0, 0, 0, 0, 0);
    wait_frame_end();

    // 3: same frame under alternating backpressure
    ready_mode = 1;
    start_frame(0, 0, 0, 0, 0);
    wait_frame_end();

    // 4: write and frame_start during RUN are held back until the next commit
    ready_mode = 1;
    start_frame(0, 0, 0, 0, 0);
    cfg_write(0, 1, 2, 3);
    start_frame(0, 0, 0, 0, 0);
    chk("camera_unchanged_in_run", camera_location, pk(4090, 2000, 1002));
    wait_frame_end();
    start_frame(1, 0, 7, 8, 9);
    chk("camera_bypass_commit", camera_location, pk(7, 8, 9));
    wait_frame_end();

    // 5: out-of-range writes, then wrap-around on x
    cfg_write(NREG, 11, 22, 33);
    cfg_write(7, 44, 55, 66);
    cfg_write(1, 4090, 0, 0);
    cfg_write(2, 10, 0, 0);
    ready_mode = 0;
    start_frame(0, 0, 0, 0, 0);
    wait_frame_end();

    // random configurations, writes during RUN, random backpressure
    for (int it = 0; it < 6; it++) begin
      ready_mode = 2;
      repeat (3) cfg_write($urandom_range(0, 7), $urandom_range(0, 4095),
                           $urandom_range(0, 4095), $urandom_range(0, 4095));
      start_frame(1, $urandom_range(0, 5), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), $urandom_range(0, 4095));
      cfg_write($urandom_range(0, 7), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 4095));
      wait_frame_end();
    end

    // 6: reset at pixel 2 aborts the frame
    ready_mode = 0;
    start_frame(0, 0, 0, 0, 0);
    t = 0;
    while (exp_q.size() > 4 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) fail_now("reach_pixel2_timeout");
    rst = 1'b1;
    exp_q.delete();
    model_defaults();
    step();
    rst = 1'b0;
    chk("abort_pix_valid",  pix_valid,  1'b0);
    chk("abort_frame_busy", frame_busy, 1'b0);
    chk("abort_pix_loc",    pix_loc,    '0);
    check_active("abort");
    repeat (5) step();

    ready_mode = 3;
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
